// File: rtl/ps2_pkg.sv
// Shared PS/2 constants: prefix bytes, Shift scan codes and the frame parity check.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  // Odd parity over data plus parity bit: the XOR of all nine bits must be 1.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_keyboard_decoder_if.sv
// Bundles the PS/2 pin inputs and the decoded key outputs of the keyboard decoder.
interface ps2_keyboard_decoder_if;

  logic       ps2_clk_async;
  logic       ps2_data_async;
  logic [7:0] scan_code;
  logic [7:0] ascii_code;
  logic       key_pressed;
  logic       key_released;

  modport master (
    output ps2_clk_async, ps2_data_async,
    input  scan_code, ascii_code, key_pressed, key_released
  );

  modport slave (
    input  ps2_clk_async, ps2_data_async,
    output scan_code, ascii_code, key_pressed, key_released
  );

endinterface

// File: rtl/ps2_keyboard_decoder_rx_frame.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit deframing,
// parity/start/stop checks and a mid-frame idle timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic [9:0]    r_shift;
  logic [3:0]    r_cnt;
  logic [TW-1:0] r_idle;
  logic          w_fall;
  logic          w_last;
  logic [10:0]   w_frame;

  // Stage [2] is the extra register on the clock line, giving prev=[2], cur=[1].
  assign w_fall  = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_last  = w_fall & (r_cnt == 4'd10);
  assign w_frame = {r_dat_sync[1], r_shift};

  assign rx_byte  = w_frame[8:1];
  assign rx_valid = w_last & ~w_frame[0] & w_frame[10] & odd_parity_ok(w_frame[9:1]);

  // Synchronizers idle at the line's high level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync <= 3'b111;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
    end
  end

  // Bit shifting, bit counting and discard of a stalled partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= 10'd0;
      r_cnt   <= 4'd0;
      r_idle  <= '0;
    end else if (w_fall) begin
      r_shift <= {r_dat_sync[1], r_shift[9:1]};
      r_cnt   <= w_last ? 4'd0 : r_cnt + 4'd1;
      r_idle  <= '0;
    end else if (r_cnt != 4'd0) begin
      if (r_idle == TW'(TIMEOUT_CYCLES - 1)) begin
        r_cnt  <= 4'd0;
        r_idle <= '0;
      end else begin
        r_idle <= r_idle + TW'(1);
      end
    end else begin
      r_idle <= '0;
    end
  end

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// Scan-code-set-2 decoder: prefix/Shift tracking, ASCII translation and key level/pulse outputs.
module ps2_keyboard_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic             clk,
  input logic             reset,
  ps2_keyboard_decoder_if.slave bus
);

  logic [7:0]  w_rx_byte;
  logic        w_rx_valid;
  logic [15:0] w_pair;
  logic [7:0]  w_ascii;
  logic        r_ext;
  logic        r_brk;
  logic        r_shift;
  logic [7:0]  r_scan;
  logic [7:0]  r_ascii;
  logic        r_pressed;
  logic        r_released;

  ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .i_ps2_clk  (bus.ps2_clk_async),
    .i_ps2_data (bus.ps2_data_async),
    .rx_byte    (w_rx_byte),
    .rx_valid   (w_rx_valid)
  );

  // Table entries are {unshifted, shifted} characters.
  always_comb begin
    w_pair = 16'h0000;
    case (w_rx_byte)
      8'h1C: w_pair = {8'h61, 8'h41};  8'h32: w_pair = {8'h62, 8'h42};
      8'h21: w_pair = {8'h63, 8'h43};  8'h23: w_pair = {8'h64, 8'h44};
      8'h24: w_pair = {8'h65, 8'h45};  8'h2B: w_pair = {8'h66, 8'h46};
      8'h34: w_pair = {8'h67, 8'h47};  8'h33: w_pair = {8'h68, 8'h48};
      8'h43: w_pair = {8'h69, 8'h49};  8'h3B: w_pair = {8'h6A, 8'h4A};
      8'h42: w_pair = {8'h6B, 8'h4B};  8'h4B: w_pair = {8'h6C, 8'h4C};
      8'h3A: w_pair = {8'h6D, 8'h4D};  8'h31: w_pair = {8'h6E, 8'h4E};
      8'h44: w_pair = {8'h6F, 8'h4F};  8'h4D: w_pair = {8'h70, 8'h50};
      8'h15: w_pair = {8'h71, 8'h51};  8'h2D: w_pair = {8'h72, 8'h52};
      8'h1B: w_pair = {8'h73, 8'h53};  8'h2C: w_pair = {8'h74, 8'h54};
      8'h3C: w_pair = {8'h75, 8'h55};  8'h2A: w_pair = {8'h76, 8'h56};
      8'h1D: w_pair = {8'h77, 8'h57};  8'h22: w_pair = {8'h78, 8'h58};
      8'h35: w_pair = {8'h79, 8'h59};  8'h1A: w_pair = {8'h7A, 8'h5A};
      8'h45: w_pair = {8'h30, 8'h29};  8'h16: w_pair = {8'h31, 8'h21};
      8'h1E: w_pair = {8'h32, 8'h40};  8'h26: w_pair = {8'h33, 8'h23};
      8'h25: w_pair = {8'h34, 8'h24};  8'h2E: w_pair = {8'h35, 8'h25};
      8'h36: w_pair = {8'h36, 8'h5E};  8'h3D: w_pair = {8'h37, 8'h26};
      8'h3E: w_pair = {8'h38, 8'h2A};  8'h46: w_pair = {8'h39, 8'h28};
      8'h29: w_pair = {8'h20, 8'h20};  8'h5A: w_pair = {8'h0D, 8'h0D};
      8'h66: w_pair = {8'h08, 8'h08};  8'h0D: w_pair = {8'h09, 8'h09};
      8'h76: w_pair = {8'h1B, 8'h1B};
      default: w_pair = 16'h0000;
    endcase
    if (r_ext) begin
      w_ascii = (w_rx_byte == 8'h5A) ? 8'h0D : 8'h00;
    end else begin
      w_ascii = r_shift ? w_pair[7:0] : w_pair[15:8];
    end
  end

  // Prefix/Shift tracking and the registered key outputs, one byte per accept cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_shift    <= 1'b0;
      r_scan     <= 8'h00;
      r_ascii    <= 8'h00;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
    end else begin
      r_released <= 1'b0;
      if (w_rx_valid) begin
        if (w_rx_byte == PS2_EXT) begin
          r_ext <= 1'b1;
        end else if (w_rx_byte == PS2_BRK) begin
          r_brk <= 1'b1;
        end else if (w_rx_byte == PS2_LSHIFT || w_rx_byte == PS2_RSHIFT) begin
          r_shift <= ~r_brk;
          r_ext   <= 1'b0;
          r_brk   <= 1'b0;
        end else if (r_brk) begin
          r_released <= 1'b1;
          if (w_rx_byte == r_scan) begin
            r_pressed <= 1'b0;
          end
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end else begin
          r_scan    <= w_rx_byte;
          r_ascii   <= w_ascii;
          r_pressed <= 1'b1;
          r_ext     <= 1'b0;
        end
      end
    end
  end

  assign bus.scan_code    = r_scan;
  assign bus.ascii_code   = r_ascii;
  assign bus.key_pressed  = r_pressed;
  assign bus.key_released = r_released;

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Directed, table-driven bench for ps2_keyboard_decoder with hand-computed expectations.
module tb_ps2_keyboard_decoder;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   rel_cnt;

  ps2_keyboard_decoder_if bus();

  ps2_keyboard_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Counts clk cycles with key_released high; each break must add exactly one.
  always @(negedge clk) begin
    if (reset) rel_cnt <= 0;
    else if (bus.key_released) rel_cnt <= rel_cnt + 1;
  end

  typedef struct {
    logic [7:0] b;
    bit         bad_par;
    bit         bad_stop;
    logic [7:0] scan;
    logic [7:0] ascii;
    bit         pressed;
    int         rel;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    bus.ps2_data_async = v;
    #100;
    bus.ps2_clk_async = 1'b0;
    #200;
    bus.ps2_clk_async = 1'b1;
    #100;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    logic        p;
    p = bad_par ? (^b) : ~(^b);
    f = {~bad_stop, p, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    #400;
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] scan, input logic [7:0] ascii,
                               input bit pressed);
    check({tag, " scan_code"}, {24'd0, bus.scan_code}, {24'd0, scan});
    check({tag, " ascii_code"}, {24'd0, bus.ascii_code}, {24'd0, ascii});
    check({tag, " key_pressed"}, {31'd0, bus.key_pressed}, {31'd0, pressed});
  endtask

  initial begin
    logic [10:0] f;
    int          rel0;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.ps2_clk_async  = 1'b1;
    bus.ps2_data_async = 1'b1;
    #100;
    reset = 1'b0;
    #40;
    check_outputs("reset", 8'h00, 8'h00, 1'b0);
    check("reset key_released", {31'd0, bus.key_released}, 32'd0);

    // Frame 1C with exact latency: outputs change one clk after the synced stop edge.
    f = {1'b1, 1'b0, 8'h1C, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    bus.ps2_data_async = f[10];
    #100;
    bus.ps2_clk_async = 1'b0;
    #40;
    check("latency early key_pressed", {31'd0, bus.key_pressed}, 32'd0);
    #20;
    check_outputs("latency", 8'h1C, 8'h61, 1'b1);
    #140;
    bus.ps2_clk_async = 1'b1;
    #500;

    vecs.push_back('{8'hF0, 1'b0, 1'b0, 8'h1C, 8'h61, 1'b1, 0});
    vecs.push_back('{8'h1C, 1'b0, 1'b0, 8'h1C, 8'h61, 1'b0, 1});
    vecs.push_back('{8'h12, 1'b0, 1'b0, 8'h1C, 8'h61, 1'b0, 0});
    vecs.push_back('{8'h1C, 1'b0, 1'b0, 8'h1C, 8'h41, 1'b1, 0});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 8'h1C, 8'h41, 1'b1, 0});
    vecs.push_back('{8'h12, 1'b0, 1'b0, 8'h1C, 8'h41, 1'b1, 0});
    vecs.push_back('{8'h16, 1'b0, 1'b0, 8'h16, 8'h31, 1'b1, 0});
    vecs.push_back('{8'h1C, 1'b1, 1'b0, 8'h16, 8'h31, 1'b1, 0});
    vecs.push_back('{8'h1C, 1'b0, 1'b1, 8'h16, 8'h31, 1'b1, 0});
    vecs.push_back('{8'h32, 1'b0, 1'b0, 8'h32, 8'h62, 1'b1, 0});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 8'h32, 8'h62, 1'b1, 0});
    vecs.push_back('{8'h1C, 1'b0, 1'b0, 8'h32, 8'h62, 1'b1, 1});
    vecs.push_back('{8'h32, 1'b0, 1'b0, 8'h32, 8'h62, 1'b1, 0});
    vecs.push_back('{8'hE0, 1'b0, 1'b0, 8'h32, 8'h62, 1'b1, 0});
    vecs.push_back('{8'h5A, 1'b0, 1'b0, 8'h5A, 8'h0D, 1'b1, 0});
    vecs.push_back('{8'hE0, 1'b0, 1'b0, 8'h5A, 8'h0D, 1'b1, 0});
    vecs.push_back('{8'h75, 1'b0, 1'b0, 8'h75, 8'h00, 1'b1, 0});
    vecs.push_back('{8'h59, 1'b0, 1'b0, 8'h75, 8'h00, 1'b1, 0});
    vecs.push_back('{8'h1E, 1'b0, 1'b0, 8'h1E, 8'h40, 1'b1, 0});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 8'h1E, 8'h40, 1'b1, 0});
    vecs.push_back('{8'h59, 1'b0, 1'b0, 8'h1E, 8'h40, 1'b1, 0});
    vecs.push_back('{8'h45, 1'b0, 1'b0, 8'h45, 8'h30, 1'b1, 0});
    vecs.push_back('{8'h5A, 1'b0, 1'b0, 8'h5A, 8'h0D, 1'b1, 0});

    foreach (vecs[i]) begin
      rel0 = rel_cnt;
      send_frame(vecs[i].b, vecs[i].bad_par, vecs[i].bad_stop);
      check_outputs($sformatf("row%0d", i), vecs[i].scan, vecs[i].ascii, vecs[i].pressed);
      check($sformatf("row%0d key_released", i), rel_cnt - rel0, vecs[i].rel);
    end

    // Six bits then 1.2 ms of idle: the partial frame must be discarded.
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    #1_200_000;
    send_frame(8'h29, 1'b0, 1'b0);
    check_outputs("timeout", 8'h29, 8'h20, 1'b1);

    // Reset in the middle of a frame drops the partial byte.
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    reset = 1'b1;
    #40;
    reset = 1'b0;
    #40;
    check_outputs("midreset", 8'h00, 8'h00, 1'b0);
    rel0 = rel_cnt;
    send_frame(8'h32, 1'b0, 1'b0);
    check_outputs("after reset", 8'h32, 8'h62, 1'b1);
    check("after reset key_released", rel_cnt - rel0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
